// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 9-bit-instruction pipelined CPU.
// Contents:
//   PC_W, INST_W, OPC_W, CNT_W  - datapath widths
//   OPC_*                       - 5-bit opcode constants (instruction bits [8:4])
//   fetch_state_t               - fetch-stage halt FSM states
//   opc_is_halt()               - opcode decode helper used by fetch
package cpu_isa_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 9;
  localparam int OPC_W  = 5;
  localparam int CNT_W  = 16;

  localparam logic [OPC_W-1:0] OPC_ADD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_SUB   = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_AND   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_OR    = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SETI  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_STORE = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_JUMP  = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_HALT  = 5'b11010;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } fetch_state_t;

  function automatic logic opc_is_halt(input logic [OPC_W-1:0] opc);
    return opc == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of all fetch-stage signals except clock and reset.
//   master : the fetch stage itself (drives pc_out, IF/ID outputs, status)
//   slave  : the environment (ROM, hazard unit, EX redirect, WB commit)
//
// Flow control: if_id_valid qualifies if_id_inst/if_id_pc every cycle
// (0 = bubble). stall acts as the consumer-side "not ready": while stall is
// high and no redirect is pending, the IF/ID contents and pc_out are held
// unchanged, so a valid word is presented until a cycle with stall low.
// redirect_en overrides stall and flushes IF/ID.
interface fetch_stage_if;
  import cpu_isa_pkg::*;

  logic [PC_W-1:0]   pc_out;
  logic [INST_W-1:0] rom_inst;
  logic              stall;
  logic              redirect_en;
  logic [PC_W-1:0]   redirect_target;
  logic              halt_commit;
  logic [INST_W-1:0] if_id_inst;
  logic [PC_W-1:0]   if_id_pc;
  logic              if_id_valid;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;
  fetch_state_t      state;        // debug view of the halt FSM

  modport master (
    output pc_out, if_id_inst, if_id_pc, if_id_valid, halted, fetch_count, state,
    input  rom_inst, stall, redirect_en, redirect_target, halt_commit
  );

  modport slave (
    input  pc_out, if_id_inst, if_id_pc, if_id_valid, halted, fetch_count, state,
    output rom_inst, stall, redirect_en, redirect_target, halt_commit
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline stage register with hold and flush.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (clears everything)
//   load_i         - capture inst_i/pc_i and mark valid
//   flush_i        - insert a bubble: valid and inst cleared, pc kept
//   inst_i, pc_i   - incoming word and its address
//   inst_o, pc_o, valid_o - registered outputs
// Priority: reset > flush > load > hold.
module if_id_reg #(
  parameter int W_INST = 9,
  parameter int W_PC   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [W_INST-1:0] inst_i,
  input  logic [W_PC-1:0]   pc_i,
  output logic [W_INST-1:0] inst_o,
  output logic [W_PC-1:0]   pc_o,
  output logic              valid_o
);

  logic [W_INST-1:0] inst_q;
  logic [W_PC-1:0]   pc_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      // pc is left alone on a bubble; only valid/inst carry meaning downstream
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC generator, halt FSM, fetch counter and IF/ID register.
// Ports:
//   clk    - clock, all state changes on posedge
//   reset  - synchronous active-high reset
//   bus    - fetch_stage_if.master: ROM address/data, stall, redirect,
//            halt commit, IF/ID outputs, halted, fetch_count, debug state
// The ROM is combinational: the word for pc_out is captured on the same edge.
module fetch_stage
  import cpu_isa_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'd1
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ifid_load, ifid_flush, cnt_inc;
  logic             rom_is_halt;

  assign rom_is_halt = opc_is_halt(bus.rom_inst[INST_W-1 -: OPC_W]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    cnt_inc    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.redirect_en) begin
          pc_d       = bus.redirect_target;
          ifid_flush = 1'b1;
        end else if (!bus.stall) begin
          ifid_load = 1'b1;
          cnt_inc   = 1'b1;
          // A HALT is delivered like any word but the PC stops on it
          if (rom_is_halt) state_d = HALT_PEND;
          else             pc_d    = pc_q + PC_W'(1);
        end
      end
      HALT_PEND: begin
        if (bus.redirect_en) begin
          // The HALT was on a mispredicted path: resume fetching
          pc_d       = bus.redirect_target;
          ifid_flush = 1'b1;
          state_d    = RUN;
        end else begin
          // Under stall IF/ID holds so decode does not lose the HALT;
          // otherwise only bubbles follow it.
          if (!bus.stall || bus.halt_commit) ifid_flush = 1'b1;
          if (bus.halt_commit) state_d = HALTED;
        end
      end
      HALTED: begin
        ifid_flush = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  if_id_reg #(
    .W_INST (INST_W),
    .W_PC   (PC_W)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .inst_i  (bus.rom_inst),
    .pc_i    (pc_q),
    .inst_o  (bus.if_id_inst),
    .pc_o    (bus.if_id_pc),
    .valid_o (bus.if_id_valid)
  );

  assign bus.pc_out      = pc_q;
  assign bus.halted      = (state_q == HALTED);
  assign bus.fetch_count = cnt_q;
  assign bus.state       = state_q;

  // Redirect and halt commit in the same cycle means EX and WB disagree
  // about an older instruction; redirect wins but this should never happen.
  always_ff @(posedge clk) begin
    if (!reset && state_q == HALT_PEND) begin
      assert (!(bus.redirect_en && bus.halt_commit));
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction ROM model.
module tb_fetch_stage;
  import cpu_isa_pkg::*;

  logic clk;
  logic reset;
  logic rom_ovr;
  int   vectors;
  int   miscompares;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ROM model ----------------
  function automatic logic [INST_W-1:0] rom_word(input logic [PC_W-1:0] pc);
    logic [INST_W-1:0] w;
    case (pc)
      16'd1:   w = {OPC_SETI, 4'b0001};
      16'd13:  w = {OPC_JUMP, 4'b0000};
      16'd14:  w = {OPC_HALT, 4'b0000};
      default: w = {OPC_ADD, pc[3:0]};
    endcase
    return w;
  endfunction

  assign bus.rom_inst = rom_ovr ? {OPC_ADD, 4'b0000} : rom_word(bus.pc_out);

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [INST_W-1:0] inst,
                            input logic [PC_W-1:0] pc, input logic valid);
    check({tag, ".inst"},  32'(bus.if_id_inst),  32'(inst));
    check({tag, ".pc"},    32'(bus.if_id_pc),    32'(pc));
    check({tag, ".valid"}, 32'(bus.if_id_valid), 32'(valid));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".pc_out"}, 32'(bus.pc_out), 32'd1);
    check_ifid(tag, '0, '0, 1'b0);
    check({tag, ".halted"}, 32'(bus.halted), 32'd0);
    check({tag, ".count"},  32'(bus.fetch_count), 32'd0);
    check({tag, ".state"},  32'(bus.state), 32'(RUN));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    rom_ovr = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_target = '0;
    bus.halt_commit = 1'b0;

    tick();
    tick();
    check_reset_state("reset");

    // 1: free-running fetch from pc 1
    reset = 1'b0;
    tick();
    check("run1.pc_out", 32'(bus.pc_out), 32'd2);
    check_ifid("run1", {OPC_SETI, 4'b0001}, 16'd1, 1'b1);
    check("run1.count", 32'(bus.fetch_count), 32'd1);
    tick();
    check("run2.pc_out", 32'(bus.pc_out), 32'd3);
    check_ifid("run2", {OPC_ADD, 4'd2}, 16'd2, 1'b1);
    tick();
    check("run3.pc_out", 32'(bus.pc_out), 32'd4);
    check_ifid("run3", {OPC_ADD, 4'd3}, 16'd3, 1'b1);
    tick();
    check("run4.pc_out", 32'(bus.pc_out), 32'd5);
    check("run4.count", 32'(bus.fetch_count), 32'd4);

    // 2: stall for two cycles at pc 5
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall.pc_out", 32'(bus.pc_out), 32'd5);
      check_ifid("stall", {OPC_ADD, 4'd4}, 16'd4, 1'b1);
      check("stall.count", 32'(bus.fetch_count), 32'd4);
    end
    bus.stall = 1'b0;
    tick();
    check("unstall.pc_out", 32'(bus.pc_out), 32'd6);
    check_ifid("unstall", {OPC_ADD, 4'd5}, 16'd5, 1'b1);
    check("unstall.count", 32'(bus.fetch_count), 32'd5);

    // 3: redirect beats stall
    bus.stall = 1'b1;
    bus.redirect_en = 1'b1;
    bus.redirect_target = 16'd13;
    tick();
    bus.stall = 1'b0;
    bus.redirect_en = 1'b0;
    check("redir.pc_out", 32'(bus.pc_out), 32'd13);
    check("redir.valid", 32'(bus.if_id_valid), 32'd0);
    check("redir.inst", 32'(bus.if_id_inst), 32'd0);
    check("redir.count", 32'(bus.fetch_count), 32'd5);
    tick();
    check_ifid("redir_tgt", {OPC_JUMP, 4'b0000}, 16'd13, 1'b1);
    check("redir_tgt.pc_out", 32'(bus.pc_out), 32'd14);

    // 4: HALT at pc 14, commit, then frozen
    tick();
    check_ifid("halt", {OPC_HALT, 4'b0000}, 16'd14, 1'b1);
    check("halt.pc_out", 32'(bus.pc_out), 32'd14);
    check("halt.state", 32'(bus.state), 32'(HALT_PEND));
    check("halt.count", 32'(bus.fetch_count), 32'd7);
    tick();
    check("bubble1.valid", 32'(bus.if_id_valid), 32'd0);
    check("bubble1.pc_out", 32'(bus.pc_out), 32'd14);
    tick();
    check("bubble2.valid", 32'(bus.if_id_valid), 32'd0);
    check("bubble2.halted", 32'(bus.halted), 32'd0);
    tick();
    bus.halt_commit = 1'b1;
    tick();
    bus.halt_commit = 1'b0;
    check("commit.halted", 32'(bus.halted), 32'd1);
    check("commit.state", 32'(bus.state), 32'(HALTED));
    for (int i = 0; i < 12; i++) begin
      bus.redirect_en = (i == 4);
      bus.redirect_target = 16'd3;
      bus.stall = (i == 6);
      tick();
      check("halted.halted", 32'(bus.halted), 32'd1);
      check("halted.pc_out", 32'(bus.pc_out), 32'd14);
      check("halted.valid", 32'(bus.if_id_valid), 32'd0);
      check("halted.count", 32'(bus.fetch_count), 32'd7);
    end
    bus.redirect_en = 1'b0;
    bus.stall = 1'b0;

    // Reset from HALTED
    reset = 1'b1;
    tick();
    check_reset_state("reset_halted");
    reset = 1'b0;

    // 5: HALT on the wrong path is cancelled by a redirect
    bus.redirect_en = 1'b1;
    bus.redirect_target = 16'd14;
    tick();
    bus.redirect_en = 1'b0;
    tick();
    check("pend.state", 32'(bus.state), 32'(HALT_PEND));
    bus.stall = 1'b1;
    tick();
    check_ifid("pend_stall", {OPC_HALT, 4'b0000}, 16'd14, 1'b1);
    bus.stall = 1'b0;
    bus.redirect_en = 1'b1;
    bus.redirect_target = 16'd8;
    tick();
    bus.redirect_en = 1'b0;
    check("cancel.state", 32'(bus.state), 32'(RUN));
    check("cancel.pc_out", 32'(bus.pc_out), 32'd8);
    check("cancel.valid", 32'(bus.if_id_valid), 32'd0);
    check("cancel.halted", 32'(bus.halted), 32'd0);
    bus.halt_commit = 1'b1;
    tick();
    bus.halt_commit = 1'b0;
    check_ifid("resume", {OPC_ADD, 4'd8}, 16'd8, 1'b1);
    check("resume.pc_out", 32'(bus.pc_out), 32'd9);
    check("resume.halted", 32'(bus.halted), 32'd0);
    check("resume.state", 32'(bus.state), 32'(RUN));
    check("resume.count", 32'(bus.fetch_count), 32'd2);

    // 6a: PC wrap
    bus.redirect_en = 1'b1;
    bus.redirect_target = 16'hFFFF;
    tick();
    bus.redirect_en = 1'b0;
    check("wrap_pre.pc_out", 32'(bus.pc_out), 32'hFFFF);
    tick();
    check("wrap.pc_out", 32'(bus.pc_out), 32'd0);
    check_ifid("wrap", {OPC_ADD, 4'hF}, 16'hFFFF, 1'b1);

    // 6b: fetch_count saturation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rom_ovr = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    check("sat_pre.count", 32'(bus.fetch_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat.count", 32'(bus.fetch_count), 32'hFFFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
